// File: rtl/crc_gen_pkg.sv
// ============================================================================
// Module      : crc_gen_pkg
// Description : Shared constants for the byte-serial CRC-32/ISO-HDLC generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package crc_gen_pkg;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT    = 32'hFFFFFFFF;
    // Register value after a message followed by its own CRC, LSB byte first.
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

endpackage : crc_gen_pkg

`default_nettype wire

// File: rtl/crc32_byte_update.sv
// ============================================================================
// Module      : crc32_byte_update
// Description : Combinational one-byte update of a reflected CRC-32 register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc32_byte_update
    import crc_gen_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] w_stage [9];

    assign w_stage[0] = crc_in ^ {24'd0, data};

    // Reflected data means the LSB is shifted out first at each of the 8 steps.
    for (genvar g = 0; g < 8; g++) begin : g_bit
        assign w_stage[g+1] = w_stage[g][0] ? ((w_stage[g] >> 1) ^ CRC_POLY_REFL)
                                            :  (w_stage[g] >> 1);
    end

    assign crc_out = w_stage[8];

endmodule : crc32_byte_update

`default_nettype wire

// File: rtl/crc_gen.sv
// ============================================================================
// Module      : crc_gen
// Description : Byte-serial CRC-32 (Ethernet/zlib) generator with byte-wide
//               read-out, LSB byte first. Optional CRC_GEN_CHECK_EN adds
//               o_crc_ok, a residue match flag for frame verification.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_gen
    import crc_gen_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_init,
    input  logic [7:0] i_data,
    input  logic       i_data_en,
    input  logic       i_data_rd,
    output logic [7:0] o_crc
`ifdef CRC_GEN_CHECK_EN
    ,
    output logic       o_crc_ok
`endif
);

    logic [31:0] r_crc;
    logic [1:0]  r_rd_ptr;
    logic [31:0] w_crc_next;
    logic [31:0] w_crc_final;

    crc32_byte_update u_byte_update (
        .crc_in  (r_crc),
        .data    (i_data),
        .crc_out (w_crc_next)
    );

    // init beats data, data beats read; any new byte rewinds the read pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc    <= CRC_INIT;
            r_rd_ptr <= 2'd0;
        end else if (i_init) begin
            r_crc    <= CRC_INIT;
            r_rd_ptr <= 2'd0;
        end else if (i_data_en) begin
            r_crc    <= w_crc_next;
            r_rd_ptr <= 2'd0;
        end else if (i_data_rd) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
        end
    end

    assign w_crc_final = r_crc ^ CRC_XOROUT;

    always_comb begin
        o_crc = w_crc_final[7:0];
        case (r_rd_ptr)
            2'd0:    o_crc = w_crc_final[7:0];
            2'd1:    o_crc = w_crc_final[15:8];
            2'd2:    o_crc = w_crc_final[23:16];
            default: o_crc = w_crc_final[31:24];
        endcase
    end

`ifdef CRC_GEN_CHECK_EN
    assign o_crc_ok = (r_crc == CRC_RESIDUE);
`endif

endmodule : crc_gen

`default_nettype wire

// File: tb/tb_crc_gen.sv
// ============================================================================
// Module      : tb_crc_gen
// Description : Self-checking bench for crc_gen: known-answer vectors, corner
//               sequences and random frames against a table-driven CRC model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_crc_gen;

    logic       i_clk     = 1'b0;
    logic       i_rst_n   = 1'b0;
    logic       i_init    = 1'b0;
    logic [7:0] i_data    = 8'h00;
    logic       i_data_en = 1'b0;
    logic       i_data_rd = 1'b0;
    logic [7:0] o_crc;
`ifdef CRC_GEN_CHECK_EN
    logic       o_crc_ok;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] crc_tab [256];

    typedef struct {
        string       name;
        int          len;
        logic [7:0]  data [16];
        logic [31:0] crc;
    } vec_t;

    always #5 i_clk = ~i_clk;

    crc_gen dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_init    (i_init),
        .i_data    (i_data),
        .i_data_en (i_data_en),
        .i_data_rd (i_data_rd),
        .o_crc     (o_crc)
`ifdef CRC_GEN_CHECK_EN
        ,
        .o_crc_ok  (o_crc_ok)
`endif
    );

    // Classic zlib-style lookup table model.
    function automatic logic [31:0] model_crc(input logic [7:0] msg [$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (msg[k]) c = crc_tab[(c ^ {24'd0, msg[k]}) & 32'hFF] ^ (c >> 8);
        return ~c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_init();
        i_init = 1'b1;
        step();
        i_init = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b);
        i_data    = b;
        i_data_en = 1'b1;
        step();
        i_data_en = 1'b0;
    endtask

    task automatic do_read();
        i_data_rd = 1'b1;
        step();
        i_data_rd = 1'b0;
    endtask

    // Checks bytes 0..3, then one more read to confirm the pointer wraps to byte 0.
    task automatic read_all(input string name, input logic [31:0] exp);
        logic [31:0] e;
        e = exp;
        check({name, " byte0"}, {24'd0, o_crc}, {24'd0, e[7:0]});
        for (int k = 1; k < 4; k++) begin
            do_read();
            check($sformatf("%s byte%0d", name, k), {24'd0, o_crc}, {24'd0, e[8*k +: 8]});
        end
        do_read();
        check({name, " wrap"}, {24'd0, o_crc}, {24'd0, e[7:0]});
    endtask

    initial begin
        vec_t        vecs [2];
        logic [7:0]  q [$];
        logic [31:0] c;

        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end

        vecs[0].name = "vec16";
        vecs[0].len  = 16;
        vecs[0].data = '{8'hBB, 8'hF4, 8'h0E, 8'hC7, 8'h9E, 8'hCE, 8'h82, 8'h34,
                         8'h16, 8'h98, 8'h28, 8'h87, 8'hBA, 8'h90, 8'h55, 8'h80};
        vecs[0].crc  = 32'hBE53A968;
        vecs[1].name = "check9";
        vecs[1].len  = 9;
        vecs[1].data = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                         8'h39, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].crc  = 32'hCBF43926;

        // Reset without init: empty-message CRC on every byte.
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        step();
        check("reset byte0", {24'd0, o_crc}, 32'h0);
        for (int k = 1; k < 4; k++) begin
            do_read();
            check($sformatf("reset byte%0d", k), {24'd0, o_crc}, 32'h0);
        end

        // Known-answer vectors.
        foreach (vecs[v]) begin
            do_init();
            for (int k = 0; k < vecs[v].len; k++) feed(vecs[v].data[k]);
            read_all(vecs[v].name, vecs[v].crc);
        end

        // Init mid-read returns pointer to byte 0 and the empty CRC.
        do_read();
        do_init();
        check("init midread byte0", {24'd0, o_crc}, 32'h0);
        do_read();
        check("init midread byte1", {24'd0, o_crc}, 32'h0);

        // Data and read together: byte absorbed, pointer rewound.
        do_init();
        feed(8'h31);
        do_read();
        i_data_rd = 1'b1;
        feed(8'h32);
        i_data_rd = 1'b0;
        q = '{8'h31, 8'h32};
        read_all("data+rd", model_crc(q));

        // Init together with data: data ignored.
        do_init();
        feed(8'h31);
        i_init = 1'b1;
        feed(8'hA5);
        i_init = 1'b0;
        read_all("init+data", 32'h0);

        // Random frames with idle gaps.
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(0, 24);
            q.delete();
            do_init();
            for (int k = 0; k < len; k++) begin
                logic [7:0] b;
                b = 8'($urandom);
                q.push_back(b);
                feed(b);
                if ($urandom_range(0, 3) == 0) step();
            end
            read_all($sformatf("rand%0d", f), model_crc(q));
        end

        // Asynchronous reset mid-frame clears state without waiting for a clock.
        do_init();
        feed(8'h12);
        feed(8'h34);
        do_read();
        #2 i_rst_n = 1'b0;
        #1 check("async rst", {24'd0, o_crc}, 32'h0);
        i_data    = 8'h55;
        i_data_en = 1'b1;
        step();
        i_data_en = 1'b0;
        i_rst_n   = 1'b1;
        step();
        read_all("after rst", 32'h0);

`ifdef CRC_GEN_CHECK_EN
        do_init();
        check("ok after init", {31'd0, o_crc_ok}, 32'd0);
        for (int k = 0; k < 9; k++) feed(vecs[1].data[k]);
        feed(8'h26); feed(8'h39); feed(8'hF4); feed(8'hCB);
        check("ok residue", {31'd0, o_crc_ok}, 32'd1);
        do_init();
        for (int k = 0; k < 9; k++) feed(vecs[1].data[k]);
        feed(8'h26); feed(8'h39); feed(8'hF4); feed(8'hCA);
        check("ok corrupt", {31'd0, o_crc_ok}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_crc_gen

`default_nettype wire

// File: doc/crc_gen.md
Name: crc_gen

Overview:
- Byte-serial CRC-32 generator: CRC-32/ISO-HDLC (Ethernet/zlib), reflected polynomial 0xEDB88320, init 0xFFFFFFFF, reflected in/out, final XOR 0xFFFFFFFF.
- Accepts one data byte per clock, then returns the finished 32-bit CRC over an 8-bit port, one byte per read cycle, LSB byte first.
- Sits beside a byte-stream framer/link to append or verify frame CRCs.

Parameters:
- None. Polynomial, init and final XOR are fixed constants from the shared package.

Ports:
- i_clk  in  1  system clock, rising-edge active.
- i_rst_n  in  1  asynchronous active-low reset.
- i_init  in  1  synchronous restart: CRC reg <= 0xFFFFFFFF, read pointer <= 0.
- i_data  in  8  data byte, processed LSB-first (reflected).
- i_data_en  in  1  i_data valid this cycle.
- i_data_rd  in  1  read strobe: advance output byte pointer.
- o_crc  out  8  currently selected byte of the finished CRC.

Behaviour:
- One clock, i_clk. Reset is asynchronous, active-low, on i_rst_n.
- State: crc_q[31:0] and rd_ptr[1:0].
- Reset values: crc_q = 0xFFFFFFFF, rd_ptr = 0. o_crc therefore reads 0x00 out of reset, since ~0xFFFFFFFF byte 0 = 0x00.
- Priority per clock edge: i_init > i_data_en > i_data_rd.
- i_init=1: crc_q <= 0xFFFFFFFF, rd_ptr <= 0. i_data_en and i_data_rd are ignored that cycle.
- i_data_en=1 (no init): crc_q <= byte_update(crc_q, i_data), rd_ptr <= 0. One byte per clock, zero wait states, back-to-back allowed.
- byte_update: c ^= {24'b0, d}; then 8 iterations of c = c[0] ? (c>>1) ^ 0xEDB88320 : (c>>1). Implemented as unrolled combinational logic.
- i_data_rd=1 (no init, no data_en): rd_ptr <= rd_ptr + 1, wrapping 3->0. crc_q is unchanged; reading is non-destructive.
- o_crc is combinational: byte rd_ptr of (crc_q ^ 0xFFFFFFFF). rd_ptr 0 selects bits[7:0], 3 selects bits[31:24].
- Read latency: byte 0 is valid in the cycle after the last data byte is clocked in. Each cycle with i_data_rd high steps to the next byte, so 4 consecutive read cycles yield the bytes LSB to MSB.
- Simultaneous i_data_en and i_data_rd: the data byte is processed and the read is ignored.
- Zero bytes since init: o_crc reads 0x00 for all four bytes (the CRC of an empty message is 0x00000000).
- Reset asserted mid-frame or mid-read: state is cleared immediately and the frame is lost.

Optional Feature:
- Macro: CRC_GEN_CHECK_EN.
- Defined: adds output o_crc_ok (1 bit, combinational), high when crc_q == 0xDEBB20E3, the residue after feeding a message followed by its own CRC LSB byte first.
- Not defined: port and logic are absent.

Decomposition:
- Package crc_gen_pkg: CRC_POLY_REFL = 32'hEDB88320, CRC_INIT = 32'hFFFFFFFF, CRC_XOROUT = 32'hFFFFFFFF, CRC_RESIDUE = 32'hDEBB20E3.
- One natural sub-module: crc32_byte_update (purely combinational: crc_in[31:0] and data[7:0] in, crc_out[31:0] out).

Test Plan:
- Reset with no init: o_crc = 0x00; after 3 read cycles it is still 0x00 on every byte.
- Init, then bytes 0xBB,0xF4,0x0E,0xC7,0x9E,0xCE,0x82,0x34,0x16,0x98,0x28,0x87,0xBA,0x90,0x55,0x80 on consecutive cycles, then 4 read cycles -> o_crc bytes 0x68,0xA9,0x53,0xBE (CRC 0xBE53A968).
- Init, ASCII "123456789", read -> bytes 0x26,0x39,0xF4,0xCB (0xCBF43926).
- Read past byte 3 (5th read) -> pointer wraps and o_crc = 0x68 again. New init mid-read -> pointer back to byte 0, crc_q = 0xFFFFFFFF.
- i_data_en and i_data_rd high together -> byte absorbed, pointer = 0. i_init with i_data_en -> data ignored.
- With CRC_GEN_CHECK_EN defined: send "123456789", then 0x26,0x39,0xF4,0xCB -> o_crc_ok = 1. Corrupt one bit -> o_crc_ok = 0.
